// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRisc core: data width, MUL/DIV operation
// codes and the state encoding of the multiply/divide unit.
package nrisc_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_MUL_LO = 2'b00,
        OP_MUL_HI = 2'b01,
        OP_DIV_Q  = 2'b10,
        OP_DIV_R  = 2'b11
    } opT;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIM  = 2'b10
    } stateT;

endpackage

// File: rtl/unidade_muldiv.sv
// Iterative unsigned multiply/divide unit. A single WIDTH+1-bit adder is
// shared: shift-add for multiplication, restoring subtraction for division.
// The {upper, lower} accumulator holds {partial product, multiplier} while
// multiplying and {remainder, quotient} while dividing.
module unidade_muldiv
    import nrisc_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Inicio,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    input  logic [3:0]       RegDestino,
    output logic             Ocupado,
    output logic [WIDTH-1:0] Resultado,
    output logic [3:0]       RegEscrito,
    output logic             EscReg,
    output logic             Pronto
);

    stateT              state;
    stateT              nextState;
    opT                 opReg;
    logic [WIDTH-1:0]   operand;
    logic [3:0]         regDest;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [CNT_W-1:0]   cnt;
    logic               isDiv;
    logic               lastIter;
    logic [WIDTH:0]     addX;
    logic [WIDTH:0]     addY;
    logic [WIDTH:0]     addSum;
    logic [WIDTH-1:0]   resultNext;

    assign isDiv    = (opReg == OP_DIV_Q) || (opReg == OP_DIV_R);
    assign lastIter = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

    // Shared adder: adds the multiplicand into the upper half, or subtracts the divisor from the shifted remainder
    always_comb begin
        addX   = '0;
        addY   = {1'b0, operand};
        addSum = '0;
        if (isDiv) begin
            // The shifted remainder is less than twice the divisor, so the
            // difference always fits a WIDTH+1-bit signed value and its MSB
            // is a reliable sign.
            addX   = acc[2*WIDTH-1:WIDTH-1];
            addSum = addX + ~addY + (WIDTH+1)'(1);
        end else begin
            addX   = {1'b0, acc[2*WIDTH-1:WIDTH]};
            addSum = addX + addY;
        end
    end

    // One iteration step of the selected algorithm and the result byte it leads to
    always_comb begin
        accNext    = acc;
        resultNext = '0;
        if (isDiv) begin
            if (!addSum[WIDTH]) begin
                accNext = {addSum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                accNext = {addSum, acc[WIDTH-1:1]};
            end else begin
                accNext = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
        case (opReg)
            OP_MUL_LO: resultNext = accNext[WIDTH-1:0];
            OP_MUL_HI: resultNext = accNext[2*WIDTH-1:WIDTH];
            OP_DIV_Q:  resultNext = accNext[WIDTH-1:0];
            OP_DIV_R:  resultNext = accNext[2*WIDTH-1:WIDTH];
            default:   resultNext = '0;
        endcase
    end

    // Next-state logic: accept in IDLE, WIDTH iterations in CALC, one result cycle in FIM
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Inicio) nextState = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) nextState = FIM;
            FIM:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operand latching on accept, then accumulator and counter stepping while calculating
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            opReg   <= OP_MUL_LO;
            operand <= '0;
            regDest <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (state == IDLE && Inicio) begin
            opReg   <= opT'(Op);
            operand <= Op[1] ? OperandoB : OperandoA;
            regDest <= RegDestino;
            acc     <= {{WIDTH{1'b0}}, (Op[1] ? OperandoA : OperandoB)};
            cnt     <= '0;
        end else if (state == CALC) begin
            acc <= accNext;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered outputs: busy flag, write strobe and the result captured on the last iteration
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Ocupado    <= 1'b0;
            EscReg     <= 1'b0;
            Pronto     <= 1'b0;
            Resultado  <= '0;
            RegEscrito <= '0;
        end else begin
            Ocupado <= (nextState != IDLE);
            EscReg  <= lastIter;
            Pronto  <= lastIter;
            if (lastIter) begin
                Resultado  <= resultNext;
                RegEscrito <= regDest;
            end
        end
    end

endmodule

// File: tb/tb_unidade_muldiv.sv
// Scoreboard bench for unidade_muldiv: every accepted operation pushes its
// expected result (from plain integer arithmetic) into a queue, and an
// independent monitor pops and compares on every write strobe.
module tb_unidade_muldiv;
    import nrisc_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic [3:0] rd;
        int         acceptCycle;
    } expT;

    logic       Clock;
    logic       Reset_n;
    logic       Inicio;
    logic [1:0] Op;
    logic [7:0] OperandoA;
    logic [7:0] OperandoB;
    logic [3:0] RegDestino;
    logic       Ocupado;
    logic [7:0] Resultado;
    logic [3:0] RegEscrito;
    logic       EscReg;
    logic       Pronto;

    expT expQ[$];
    int  cycle;
    int  vectors;
    int  miscompares;

    unidade_muldiv #(.WIDTH(8), .CNT_W(3)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Inicio     (Inicio),
        .Op         (Op),
        .OperandoA  (OperandoA),
        .OperandoB  (OperandoB),
        .RegDestino (RegDestino),
        .Ocupado    (Ocupado),
        .Resultado  (Resultado),
        .RegEscrito (RegEscrito),
        .EscReg     (EscReg),
        .Pronto     (Pronto)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle <= cycle + 1;

    // Reference behaviour straight from unsigned arithmetic
    function automatic logic [7:0] refModel(logic [7:0] a, logic [7:0] b, logic [1:0] op);
        logic [15:0] p;
        p = {8'b0, a} * {8'b0, b};
        case (op)
            2'b00:   return p[7:0];
            2'b01:   return p[15:8];
            2'b10:   return (b == 8'h00) ? 8'hFF : a / b;
            default: return (b == 8'h00) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(logic [7:0] a, logic [7:0] b, logic [1:0] op, logic [3:0] rd);
        expT e;
        @(negedge Clock);
        Inicio     = 1'b1;
        OperandoA  = a;
        OperandoB  = b;
        Op         = op;
        RegDestino = rd;
        @(posedge Clock);
        #1;
        e.res         = refModel(a, b, op);
        e.rd          = rd;
        e.acceptCycle = cycle;
        expQ.push_back(e);
        checkOutput("ocupado_after_accept", int'(Ocupado), 1);
        @(negedge Clock);
        Inicio     = 1'b0;
        OperandoA  = 8'($urandom);
        OperandoB  = 8'($urandom);
        Op         = 2'($urandom);
        RegDestino = 4'($urandom);
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (!Ocupado) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_idle: Ocupado still 1 after 20 cycles, expected 0");
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge Clock) begin
        expT e;
        if (EscReg || Pronto) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL strobe_unexpected: EscReg=%0b Pronto=%0b Resultado=0x%0h, expected no strobe",
                         EscReg, Pronto, Resultado);
            end else begin
                e = expQ.pop_front();
                checkOutput("resultado", int'(Resultado), int'(e.res));
                checkOutput("reg_escrito", int'(RegEscrito), int'(e.rd));
                checkOutput("pronto_eq_escreg", int'({EscReg, Pronto}), 3);
                checkOutput("latency", cycle - e.acceptCycle, 8);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        bit         ok;

        cycle       = 0;
        vectors     = 0;
        miscompares = 0;
        Reset_n     = 1'b0;
        Inicio      = 1'b0;
        Op          = 2'b00;
        OperandoA   = 8'h00;
        OperandoB   = 8'h00;
        RegDestino  = 4'h0;

        repeat (3) @(posedge Clock);
        #1;
        checkOutput("reset_ocupado", int'(Ocupado), 0);
        checkOutput("reset_escreg", int'(EscReg), 0);
        checkOutput("reset_pronto", int'(Pronto), 0);
        checkOutput("reset_resultado", int'(Resultado), 0);
        checkOutput("reset_regescrito", int'(RegEscrito), 0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Directed cases
        applyStimulus(8'h0D, 8'h0B, 2'b00, 4'h1); waitIdle();
        applyStimulus(8'h0D, 8'h0B, 2'b01, 4'h2); waitIdle();
        applyStimulus(8'hC8, 8'hC8, 2'b01, 4'h3); waitIdle();
        applyStimulus(8'hC8, 8'hC8, 2'b00, 4'h3); waitIdle();
        applyStimulus(8'h64, 8'h07, 2'b10, 4'h4); waitIdle();
        applyStimulus(8'h64, 8'h07, 2'b11, 4'h5); waitIdle();
        applyStimulus(8'h5A, 8'h00, 2'b10, 4'h6); waitIdle();
        applyStimulus(8'h5A, 8'h00, 2'b11, 4'h7); waitIdle();
        applyStimulus(8'hFF, 8'hFF, 2'b01, 4'hF); waitIdle();
        applyStimulus(8'hFF, 8'h01, 2'b10, 4'hE); waitIdle();

        // Start request in the middle of an operation must be ignored
        applyStimulus(8'h0D, 8'h0B, 2'b00, 4'h9);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!Ocupado) ok = 1'b0;
            if (i == 2) begin
                Inicio     = 1'b1;
                OperandoA  = 8'h33;
                OperandoB  = 8'h05;
                Op         = 2'b10;
                RegDestino = 4'hA;
            end
            if (i == 3) Inicio = 1'b0;
            @(negedge Clock);
        end
        if (!Ocupado) ok = 1'b0;
        checkOutput("ocupado_continuous", int'(ok), 1);
        waitIdle();
        repeat (3) @(negedge Clock);
        checkOutput("ignored_start_queue", expQ.size(), 0);

        // Reset in flight aborts the operation without a strobe
        applyStimulus(8'h77, 8'h03, 2'b10, 4'hB);
        repeat (4) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_ocupado", int'(Ocupado), 0);
        checkOutput("abort_escreg", int'(EscReg), 0);
        checkOutput("abort_pronto", int'(Pronto), 0);
        checkOutput("abort_resultado", int'(Resultado), 0);
        checkOutput("abort_regescrito", int'(RegEscrito), 0);
        expQ.delete();
        repeat (12) @(negedge Clock);
        Reset_n = 1'b1;
        applyStimulus(8'h77, 8'h03, 2'b10, 4'hB); waitIdle();

        // Randomized operations, with an occasional zero divisor
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(a, b, 2'($urandom), 4'($urandom));
            waitIdle();
        end

        repeat (5) @(negedge Clock);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
